// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - PS/2 scan-code set 2 constants and keyboard FSM encoding
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;
  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } ps2_state_t;

  // Digits below cnt are lit; an empty buffer optionally keeps digit 0 lit to show "0".
  function automatic logic [7:0] mask_from_count(input logic [3:0] cnt, input logic show_zero);
    logic [7:0] m;
    m = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(cnt)) m[i] = 1'b0;
    end
    if (cnt == 4'd0 && show_zero) m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/scancode_to_hex.sv
// rtl/scancode_to_hex.sv - combinational set-2 make code to hex nibble decoder
module scancode_to_hex
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic       is_hex,
  output logic [3:0] nibble
);

  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    case (code)
      SC_0: nibble = 4'h0;
      SC_1: nibble = 4'h1;
      SC_2: nibble = 4'h2;
      SC_3: nibble = 4'h3;
      SC_4: nibble = 4'h4;
      SC_5: nibble = 4'h5;
      SC_6: nibble = 4'h6;
      SC_7: nibble = 4'h7;
      SC_8: nibble = 4'h8;
      SC_9: nibble = 4'h9;
      SC_A: nibble = 4'hA;
      SC_B: nibble = 4'hB;
      SC_C: nibble = 4'hC;
      SC_D: nibble = 4'hD;
      SC_E: nibble = 4'hE;
      SC_F: nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/digit_entry_buffer.sv
// rtl/digit_entry_buffer.sv - PS/2 hex digit entry buffer driving the 8-digit display
module digit_entry_buffer
  import ps2_pkg::*;
#(
  parameter bit SHOW_ZERO_WHEN_EMPTY = 1'b1,
  parameter int MAX_DIGITS           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        data_valid,
  input  logic        rx_error,
  output logic [31:0] NUMB,
  output logic [7:0]  MASK,
  output logic        ERROR,
  output logic [3:0]  count
);

  localparam logic [3:0] MAX_CNT    = 4'(MAX_DIGITS);
  localparam logic [7:0] MASK_EMPTY = mask_from_count(4'd0, SHOW_ZERO_WHEN_EMPTY);

  ps2_state_t state;
  logic       is_hex;
  logic [3:0] nibble;

  scancode_to_hex u_decode (
    .code   (data),
    .is_hex (is_hex),
    .nibble (nibble)
  );

  // MASK is updated alongside count so it never lags the digit count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      NUMB  <= 32'h0;
      count <= 4'd0;
      ERROR <= 1'b0;
      MASK  <= MASK_EMPTY;
    end else if (rx_error) begin
      ERROR <= 1'b1;
      state <= S_IDLE;
    end else if (data_valid) begin
      case (state)
        S_IDLE: begin
          if (data == SC_BREAK) begin
            state <= S_BREAK;
          end else if (data == SC_EXT) begin
            state <= S_EXT;
          end else if (is_hex) begin
            if (count < MAX_CNT) begin
              NUMB  <= {NUMB[27:0], nibble};
              count <= count + 4'd1;
              MASK  <= mask_from_count(count + 4'd1, SHOW_ZERO_WHEN_EMPTY);
              ERROR <= 1'b0;
            end else begin
              ERROR <= 1'b1;
            end
          end else if (data == SC_BKSP) begin
            if (count != 4'd0) begin
              NUMB  <= {4'h0, NUMB[31:4]};
              count <= count - 4'd1;
              MASK  <= mask_from_count(count - 4'd1, SHOW_ZERO_WHEN_EMPTY);
              ERROR <= 1'b0;
            end
          end else if (data == SC_ESC) begin
            NUMB  <= 32'h0;
            count <= 4'd0;
            MASK  <= MASK_EMPTY;
            ERROR <= 1'b0;
          end else begin
            ERROR <= 1'b1;
          end
        end
        // Extended keys are swallowed silently, including their break sequence.
        S_EXT:   state <= (data == SC_BREAK) ? S_EXT_BREAK : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_entry_buffer.sv
// tb/tb_digit_entry_buffer.sv - self-checking bench for digit_entry_buffer
module tb_digit_entry_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        data_valid;
  logic        rx_error;
  logic [31:0] NUMB;
  logic [7:0]  MASK;
  logic        ERROR;
  logic [3:0]  count;

  always #5 clk = ~clk;

  digit_entry_buffer #(
    .SHOW_ZERO_WHEN_EMPTY (1'b1),
    .MAX_DIGITS           (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data       (data),
    .data_valid (data_valid),
    .rx_error   (rx_error),
    .NUMB       (NUMB),
    .MASK       (MASK),
    .ERROR      (ERROR),
    .count      (count)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  // Reference model: held digits, most recent at index 0.
  int q[$];
  bit m_err;
  int pend;   // 0 = fresh code, 1 = discard next byte, 2 = after extended prefix

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int hex_index(input logic [7:0] b);
    for (int i = 0; i < 16; i++) if (hex_codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_numb();
    logic [31:0] r = 32'h0;
    for (int i = 0; i < q.size(); i++) r = r | (32'(q[i]) << (4 * i));
    return r;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [15:0] t;
    if (q.size() == 0) return 8'hFE;
    t = 16'h00FF << q.size();
    return t[7:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_err = 1'b0;
    pend  = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int h;
    if (pend == 1) begin
      pend = 0;
    end else if (pend == 2) begin
      pend = (b == 8'hF0) ? 1 : 0;
    end else if (b == 8'hF0) begin
      pend = 1;
    end else if (b == 8'hE0) begin
      pend = 2;
    end else begin
      h = hex_index(b);
      if (h >= 0) begin
        if (q.size() < 8) begin
          q.push_front(h);
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end else if (b == 8'h66) begin
        if (q.size() > 0) begin
          void'(q.pop_front());
          m_err = 1'b0;
        end
      end else if (b == 8'h76) begin
        q.delete();
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_numb"},  NUMB,  m_numb());
    check({tag, "_count"}, 32'(count), 32'(q.size()));
    check({tag, "_mask"},  32'(MASK),  32'(m_mask()));
    check({tag, "_error"}, 32'(ERROR), 32'(m_err));
  endtask

  task automatic send(input string tag, input logic [7:0] b, input bit err = 1'b0, input bit dv = 1'b1);
    @(negedge clk);
    data       = b;
    data_valid = dv;
    rx_error   = err;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    rx_error   = 1'b0;
    if (err) begin
      m_err = 1'b1;
      pend  = 0;
    end else if (dv) begin
      model_byte(b);
    end
    check_all(tag);
  endtask

  task automatic press(input string tag, input logic [7:0] b);
    send(tag, b);
    send(tag, 8'hF0);
    send(tag, b);
  endtask

  initial begin
    int r;
    rst        = 1'b0;
    data       = 8'h00;
    data_valid = 1'b0;
    rx_error   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Two digits with break sequences.
    press("dig12", 8'h16);
    press("dig12", 8'h1E);
    check("dig12_value", NUMB, 32'h00000012);
    check("dig12_mask", 32'(MASK), 32'hFC);

    // Fill to capacity, then overflow, then backspace.
    send("esc0", 8'h76);
    for (int i = 1; i <= 8; i++) press("fill", hex_codes[i]);
    check("full_value", NUMB, 32'h12345678);
    check("full_mask", 32'(MASK), 32'h00);
    press("overflow", hex_codes[9]);
    check("overflow_err", 32'(ERROR), 32'h1);
    send("bksp", 8'h66);
    check("bksp_value", NUMB, 32'h01234567);
    check("bksp_count", 32'(count), 32'd7);

    // Empty buffer edge cases.
    send("esc1", 8'h76);
    send("bksp_empty", 8'h66);
    send("unknown", 8'h1A);
    check("unknown_err", 32'(ERROR), 32'h1);
    send("esc2", 8'h76);

    // Extended keys are ignored.
    send("ext", 8'hE0);
    send("ext", 8'h75);
    send("ext_brk", 8'hE0);
    send("ext_brk", 8'hF0);
    send("ext_brk", 8'h75);
    send("after_ext", 8'h45);
    check("after_ext_count", 32'(count), 32'd1);

    // Receiver error aborts a break sequence.
    send("rxe_brk", 8'hF0);
    send("rxe", 8'h00, 1'b1, 1'b0);
    check("rxe_err", 32'(ERROR), 32'h1);
    send("rxe_next", 8'h16);
    check("rxe_next_nib", 32'(NUMB[3:0]), 32'h1);
    send("rxe_same", 8'h1E, 1'b1, 1'b1);

    // Async reset with no clock edge.
    send("esc3", 8'h76);
    for (int i = 0; i < 5; i++) press("pre_rst", hex_codes[i + 3]);
    send("mid_brk", 8'hF0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b1;

    // Typematic repeats.
    send("typ", 8'h2E);
    send("typ", 8'h2E);
    send("typ", 8'h2E);
    check("typ_value", NUMB, 32'h00000555);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      send("rnd_hex", hex_codes[$urandom_range(0, 15)]);
      else if (r < 60) send("rnd_brk", 8'hF0);
      else if (r < 65) send("rnd_ext", 8'hE0);
      else if (r < 75) send("rnd_bksp", 8'h66);
      else if (r < 78) send("rnd_esc", 8'h76);
      else if (r < 83) send("rnd_byte", 8'($urandom_range(0, 255)));
      else if (r < 88) send("rnd_rxe", 8'h00, 1'b1, 1'b0);
      else if (r < 91) send("rnd_rxe_dv", hex_codes[$urandom_range(0, 15)], 1'b1, 1'b1);
      else             send("rnd_idle", 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_entry_buffer.md
Name: digit_entry_buffer

Overview:
Sits directly upstream of the 8-digit seven-segment display controller, between the PS/2 byte receiver and the display. It consumes PS/2 scan-code set 2 bytes and interprets make codes for 0-9/A-F as hex digits, Backspace as delete and Esc as clear. It holds the entered number and drives the display's NUMB, MASK and ERROR inputs directly. A break/extended-prefix FSM ensures each key press acts exactly once per make code.

Parameters:
SHOW_ZERO_WHEN_EMPTY, 1, when 1 and no digits are held, digit 0 stays unblanked so "0" is shown; when 0, all digits are blanked.
MAX_DIGITS, 8, digit capacity, 1..8. Fixed at 8 for the current display.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
data  input  8  received PS/2 byte, valid only while data_valid=1
data_valid  input  1  one-cycle strobe from the PS/2 receiver
rx_error  input  1  one-cycle strobe, receiver parity/framing error
NUMB  output  32  entered number; nibble 0 is the most recently typed digit
MASK  output  8  bit i=1 blanks display digit i
ERROR  output  1  sticky error flag to the display
count  output  4  number of digits held, 0..MAX_DIGITS

Behaviour:
- Reset (rst=0, async) forces NUMB=0, count=0, ERROR=0, FSM=S_IDLE. MASK=8'hFE if SHOW_ZERO_WHEN_EMPTY, else 8'hFF.
- All outputs are registered. Every action takes effect on the rising edge that samples data_valid=1, so outputs are valid the following cycle.
- MASK is a pure function of count: bits [count-1:0]=0 and the rest 1. The count=0 case follows the parameter rule above.
- FSM states and transitions (all evaluated only when data_valid=1):
  - S_IDLE: 0xF0 -> S_BREAK; 0xE0 -> S_EXT; any other byte is processed as a make code and the FSM stays in S_IDLE.
  - S_BREAK: any byte -> S_IDLE; the byte is discarded.
  - S_EXT: 0xF0 -> S_EXT_BREAK; any other byte -> S_IDLE, discarded. Extended keys are ignored and do not raise an error.
  - S_EXT_BREAK: any byte -> S_IDLE, discarded.
- Make-code actions in S_IDLE:
  - Hex digit make codes: 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9, 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
  - Hex digit, count<MAX_DIGITS: NUMB <= {NUMB[27:0], nibble}, count+1, ERROR<=0.
  - Hex digit, count==MAX_DIGITS (overflow): NUMB and count are unchanged; ERROR<=1.
  - Backspace 0x66: if count>0, NUMB <= {4'h0, NUMB[31:4]}, count-1, ERROR<=0. If count==0, no change and no error.
  - Esc 0x76: NUMB=0, count=0, ERROR=0.
  - Any other byte: NUMB and count are unchanged; ERROR<=1.
- Typematic repeats (repeated make codes while a key is held) are treated as new presses and each one appends a digit.
- rx_error=1: ERROR<=1, FSM -> S_IDLE, NUMB and count unchanged.
  - If data_valid is also 1 in the same cycle, rx_error wins and the byte is discarded.
- ERROR is sticky. It is cleared only by an accepted digit, a backspace with count>0, Esc, or reset.
- Reset asserted mid-sequence (for example, while in S_BREAK) returns the FSM to S_IDLE, so the next byte is treated as a fresh code.

Decomposition:
- Shared package ps2_pkg holds:
  - Scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_BKSP=66, SC_ESC=76, and the sixteen hex-key codes.
  - The 2-bit FSM state encoding (S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK).
- One combinational sub-module, scancode_to_hex: input 8-bit code; outputs is_hex and a 4-bit nibble. It is reused by the other keyboard consumers.

Test Plan:
- Reset, then bytes 16, F0,16, 1E, F0,1E -> NUMB=0x00000012, count=2, MASK=FC, ERROR=0. Each break sequence causes no change.
- Nine digit presses 1..9 (each followed by F0,xx) -> after the 8th press NUMB=0x12345678, MASK=00. After the 9th press NUMB is unchanged and ERROR=1. A following 66 gives NUMB=0x01234567, count=7, ERROR=0.
- Empty buffer, 66 -> no change, ERROR=0, MASK=FE. Then 0x1A (unknown key) -> ERROR=1. Then 76 -> ERROR=0, NUMB=0.
- E0,75 (arrow key) then E0,F0,75 -> NUMB and count unchanged, ERROR=0, FSM back in S_IDLE. The next byte 45 appends 0 (count+1).
- F0 then rx_error pulse, then 16 -> ERROR=1 after the pulse; 16 is accepted as a make code, giving NUMB nibble0=1 and ERROR=0. Same-cycle data_valid(16)+rx_error -> byte is dropped.
- Async reset asserted mid-cycle while count=5 -> outputs clear immediately, without waiting for a clock edge. Repeated make 2E,2E,2E with no break codes -> NUMB=0x555, count=3.
